// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multicycle control unit: field codes, states, control word.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package mc_ctrl_pkg;

  localparam int OP_W     = 6;
  localparam int FUNCT_W  = 6;
  localparam int ALUCTL_W = 3;

  // Opcodes (Instr[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  // R-type funct codes (Instr[5:0])
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  // ALU operation codes driven to the datapath
  localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // Coarse ALU operation class; FUNCT defers to the instruction's funct field.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // Per-state control word held in the output register.
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    aluop_t     alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       done;
  } ctrl_t;

  // Moore output table: control word presented while sitting in state s.
  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c        = '0;
    c.alu_op = ALUOP_ADD;
    case (s)
      S_FETCH: begin
        c.alu_src_b = 2'b01;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.done       = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
        c.done      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_SUB;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
        c.done      = 1'b1;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      S_JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
        c.done     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Instruction fields and Zero in, datapath control out, between controller and datapath.
// Latency: n/a (wires only).
// Backpressure: none; the controller advances one state every cycle.
interface mc_control_fsm_if;
  import mc_ctrl_pkg::*;

  logic [OP_W-1:0]     Op;
  logic [FUNCT_W-1:0]  Funct;
  logic                Zero;
  logic                IorD;
  logic                MemWrite;
  logic                IRWrite;
  logic                RegDst;
  logic                MemtoReg;
  logic                RegWrite;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [ALUCTL_W-1:0] ALUControl;
  logic [1:0]          PCSrc;
  logic                PCEn;
  logic                instr_done;

  // Datapath side: supplies instruction fields and Zero, consumes controls.
  modport master (
    output Op, Funct, Zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, instr_done
  );

  // Controller side.
  modport slave (
    input  Op, Funct, Zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, instr_done
  );
endinterface

// File: rtl/mc_control_fsm_alu_decoder.sv
// Maps ALU operation class plus funct field to the 3-bit ALU op.
// Latency: combinational.
// Backpressure: none.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  aluop_t              alu_op,
  input  logic [FUNCT_W-1:0]  funct,
  output logic [ALUCTL_W-1:0] alu_control
);

  // Class decode; unknown funct falls back to add so writeback stays harmless.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle Moore control FSM sequencing fetch/decode/execute/memory/writeback.
// Latency: outputs registered with the state; PCEn alone follows Zero in the same cycle.
// Backpressure: none; one state per cycle, one instruction in flight.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mc_control_fsm_if.slave   bus
);

  state_t              state;
  state_t              state_nxt;
  ctrl_t               ctrl;
  logic [ALUCTL_W-1:0] alu_control;

  // Next-state selection from current state and opcode.
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: state_nxt = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt = S_MEMWB;
      S_EXEC:   state_nxt = S_ALUWB;
      S_ADDIEX: state_nxt = S_ADDIWB;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // State register with the control word loaded alongside it, so outputs are glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      ctrl  <= state_ctrl(S_FETCH);
    end else begin
      state <= state_nxt;
      ctrl  <= state_ctrl(state_nxt);
    end
  end

  alu_decoder u_alu_decoder (
    .alu_op      (ctrl.alu_op),
    .funct       (bus.Funct),
    .alu_control (alu_control)
  );

  // Enables are gated by reset so nothing writes while reset is held, even mid-instruction.
  assign bus.IorD       = ctrl.iord;
  assign bus.MemWrite   = ctrl.mem_write & ~reset;
  assign bus.IRWrite    = ctrl.ir_write & ~reset;
  assign bus.RegDst     = ctrl.reg_dst;
  assign bus.MemtoReg   = ctrl.mem_to_reg;
  assign bus.RegWrite   = ctrl.reg_write & ~reset;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.PCSrc      = ctrl.pc_src;
  assign bus.PCEn       = ~reset & (ctrl.pc_write | (ctrl.branch & bus.Zero));
  assign bus.instr_done = ctrl.done & ~reset;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench: driver queues the expected control vector per cycle, monitor compares at negedge.
// Latency: one expected vector per clock cycle.
// Backpressure: none.
module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

  logic clk;
  logic reset;
  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA ALUSrcB[2] ALUControl[3] PCSrc[2] PCEn instr_done
  localparam logic [15:0] V_FETCH  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,3'b010,2'b00,1'b1,1'b0};
  localparam logic [15:0] V_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b010,2'b00,1'b0,1'b0};
  localparam logic [15:0] V_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b010,2'b00,1'b0,1'b0};
  localparam logic [15:0] V_MEMRD  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b010,2'b00,1'b0,1'b0};
  localparam logic [15:0] V_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,3'b010,2'b00,1'b0,1'b1};
  localparam logic [15:0] V_MEMWR  = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b010,2'b00,1'b0,1'b1};
  localparam logic [15:0] V_ALUWB  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,3'b010,2'b00,1'b0,1'b1};
  localparam logic [15:0] V_ADDIEX = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b010,2'b00,1'b0,1'b0};
  localparam logic [15:0] V_ADDIWB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,3'b010,2'b00,1'b0,1'b1};
  localparam logic [15:0] V_JUMP   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b010,2'b10,1'b1,1'b1};
  // Enable bits only: MemWrite, IRWrite, RegWrite, PCEn, instr_done
  localparam logic [15:0] M_EN     = 16'h6403;
  localparam logic [15:0] M_ALL    = 16'hFFFF;

  function automatic logic [15:0] v_exec(input logic [2:0] aluc);
    return {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,aluc,2'b00,1'b0,1'b0};
  endfunction

  function automatic logic [15:0] v_branch(input logic z);
    return {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b110,2'b01,z,1'b1};
  endfunction

  typedef struct {
    string       name;
    logic [15:0] vec;
    logic [15:0] mask;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  wire [15:0] act = {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                     bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                     bus.PCSrc, bus.PCEn, bus.instr_done};

  // Monitor: one queued expectation per cycle, compared away from the active edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (((act ^ e.vec) & e.mask) !== 16'h0) begin
        errors++;
        $display("FAIL %s: got %b required %b (mask %b)", e.name, act, e.vec, e.mask);
      end
    end
  end

  // Queue the expectation for the current cycle, then advance to just after the next edge.
  task automatic cyc(input string n, input logic [15:0] v, input logic [15:0] m);
    exp_t e;
    e.name = n;
    e.vec  = v;
    e.mask = m;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic z);
    bus.Op    = op;
    bus.Funct = fn;
    bus.Zero  = z;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_in(6'b000000, 6'b000000, 1'b0);
    @(posedge clk);
    #1;
    cyc("reset_init", 16'h0, M_EN);
    reset = 1'b0;

    // Test 1: lw aborted by reset held 3 cycles starting in MEMRD
    set_in(OP_LW, 6'b000000, 1'b0);
    cyc("t1_fetch",  V_FETCH,  M_ALL);
    cyc("t1_decode", V_DECODE, M_ALL);
    cyc("t1_memadr", V_MEMADR, M_ALL);
    reset = 1'b1;
    cyc("t1_rst0", 16'h0, M_EN);
    cyc("t1_rst1", 16'h0, M_EN);
    cyc("t1_rst2", 16'h0, M_EN);
    reset = 1'b0;

    // Test 2: full lw, 5 cycles
    set_in(OP_LW, 6'b000000, 1'b0);
    cyc("t2_fetch",  V_FETCH,  M_ALL);
    cyc("t2_decode", V_DECODE, M_ALL);
    cyc("t2_memadr", V_MEMADR, M_ALL);
    cyc("t2_memrd",  V_MEMRD,  M_ALL);
    cyc("t2_memwb",  V_MEMWB,  M_ALL);

    // Test 3: R-type slt, then the other funct codes including an unknown one
    set_in(OP_RTYPE, FN_SLT, 1'b0);
    cyc("t3_fetch",  V_FETCH,      M_ALL);
    cyc("t3_decode", V_DECODE,     M_ALL);
    cyc("t3_exec",   v_exec(3'b111), M_ALL);
    cyc("t3_aluwb",  V_ALUWB,      M_ALL);
    set_in(OP_RTYPE, FN_SUB, 1'b0);
    cyc("t3s_fetch",  V_FETCH,        M_ALL);
    cyc("t3s_decode", V_DECODE,       M_ALL);
    cyc("t3s_exec",   v_exec(3'b110), M_ALL);
    cyc("t3s_aluwb",  V_ALUWB,        M_ALL);
    set_in(OP_RTYPE, FN_AND, 1'b0);
    cyc("t3a_fetch",  V_FETCH,        M_ALL);
    cyc("t3a_decode", V_DECODE,       M_ALL);
    cyc("t3a_exec",   v_exec(3'b000), M_ALL);
    cyc("t3a_aluwb",  V_ALUWB,        M_ALL);
    set_in(OP_RTYPE, FN_OR, 1'b0);
    cyc("t3o_fetch",  V_FETCH,        M_ALL);
    cyc("t3o_decode", V_DECODE,       M_ALL);
    cyc("t3o_exec",   v_exec(3'b001), M_ALL);
    cyc("t3o_aluwb",  V_ALUWB,        M_ALL);
    set_in(OP_RTYPE, 6'b111000, 1'b0);
    cyc("t3u_fetch",  V_FETCH,        M_ALL);
    cyc("t3u_decode", V_DECODE,       M_ALL);
    cyc("t3u_exec",   v_exec(3'b010), M_ALL);
    cyc("t3u_aluwb",  V_ALUWB,        M_ALL);

    // Test 4: beq taken then not taken, 3 cycles each
    set_in(OP_BEQ, 6'b000000, 1'b1);
    cyc("t4t_fetch",  V_FETCH,        M_ALL);
    cyc("t4t_decode", V_DECODE,       M_ALL);
    cyc("t4t_branch", v_branch(1'b1), M_ALL);
    set_in(OP_BEQ, 6'b000000, 1'b0);
    cyc("t4n_fetch",  V_FETCH,        M_ALL);
    cyc("t4n_decode", V_DECODE,       M_ALL);
    cyc("t4n_branch", v_branch(1'b0), M_ALL);

    // Test 5: undefined opcode returns to FETCH after DECODE
    set_in(6'b111111, 6'b000000, 1'b0);
    cyc("t5_fetch",  V_FETCH,  M_ALL);
    cyc("t5_decode", V_DECODE, M_ALL);

    // Test 6: back-to-back sw, addi, j
    set_in(OP_SW, 6'b000000, 1'b0);
    cyc("t6s_fetch",  V_FETCH,  M_ALL);
    cyc("t6s_decode", V_DECODE, M_ALL);
    cyc("t6s_memadr", V_MEMADR, M_ALL);
    cyc("t6s_memwr",  V_MEMWR,  M_ALL);
    set_in(OP_ADDI, 6'b000000, 1'b0);
    cyc("t6a_fetch",  V_FETCH,  M_ALL);
    cyc("t6a_decode", V_DECODE, M_ALL);
    cyc("t6a_addiex", V_ADDIEX, M_ALL);
    cyc("t6a_addiwb", V_ADDIWB, M_ALL);
    set_in(OP_J, 6'b000000, 1'b0);
    cyc("t6j_fetch",  V_FETCH,  M_ALL);
    cyc("t6j_decode", V_DECODE, M_ALL);
    cyc("t6j_jump",   V_JUMP,   M_ALL);
    cyc("t6_refetch", V_FETCH,  M_ALL);

    @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
